latch_write_sequencer: RTL and testbench



---
 rtl/latch_seq_pkg.sv | 28 ++
 rtl/latch_write_sequencer_rr_arbiter.sv | 34 +++
 rtl/latch_write_sequencer.sv | 116 +++++++++++
 tb/tb_latch_write_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch write sequencer: FSM state encoding and
// constant-width helpers used to size ports and counters.
package latch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/latch_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr,
// searching upward with wrap; returns one-hot grant and its index.
module rr_arbiter
  import latch_seq_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]        req,
  input  logic [clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        gnt,
  output logic [clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned IW = clog2(NREQ);

  int unsigned k;
  logic        found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr) + i) % NREQ;
      if (!found && req[k]) begin
        gnt[k]  = 1'b1;
        gnt_idx = IW'(k);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/latch_write_sequencer.sv
// Serialises requester writes into a shared level-sensitive latch bank with a
// fixed setup / enable / hold window around each enable pulse.
module latch_write_sequencer
  import latch_seq_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned EN_CYC    = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DW-1:0]     wdata,
  output logic [DW-1:0]          latch_d,
  output logic                   latch_en,
  output logic [NREQ-1:0]        ack,
  output logic [clog2(NREQ)-1:0] gnt_id,
  output logic                   busy
);

  localparam int unsigned IW = clog2(NREQ);
  localparam int unsigned CW = clog2(max3(SETUP_CYC, EN_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gnt_id_q, gnt_id_d;
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]     latch_d_q, latch_d_d;
  logic              latch_en_q, latch_en_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic [DW-1:0]     wd [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_wd
    assign wd[i] = wdata[i*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    gnt_oh_d  = gnt_oh_q;
    latch_d_d = latch_d_q;
    unique case (state_q)
      IDLE: if (|req) begin
        state_d   = SETUP;
        cnt_d     = SETUP_LD;
        gnt_id_d  = arb_idx;
        gnt_oh_d  = arb_gnt;
        latch_d_d = wd[arb_idx];
        ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
      end
      SETUP: if (cnt_q == '0) begin
        state_d = ENABLE;
        cnt_d   = EN_LD;
      end else cnt_d = cnt_q - 1'b1;
      ENABLE: if (cnt_q == '0) begin
        state_d = HOLD;
        cnt_d   = HOLD_LD;
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) state_d = IDLE;
      else cnt_d = cnt_q - 1'b1;
    endcase
    // Outputs are decoded from the next state so each one leaves a flop directly.
    latch_en_d = (state_d == ENABLE);
    busy_d     = (state_d != IDLE);
    ack_d      = (state_d == HOLD && cnt_d == '0) ? gnt_oh_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      gnt_oh_q   <= '0;
      ack_q      <= '0;
      latch_d_q  <= '0;
      latch_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      gnt_oh_q   <= gnt_oh_d;
      ack_q      <= ack_d;
      latch_d_q  <= latch_d_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
    end
  end

  assign latch_d  = latch_d_q;
  assign latch_en = latch_en_q;
  assign ack      = ack_q;
  assign gnt_id   = gnt_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: directed vector table, reset/fairness/stability
// sequences, random traffic against a transaction-level model, and a timing sweep.
module tb_latch_write_sequencer;

  localparam int NREQ = 4;
  localparam int S = 1, E = 2, H = 1;
  localparam int L = S + E + H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [7:0]  latch_d;
  logic        latch_en;
  logic [3:0]  ack;
  logic [1:0]  gnt_id;
  logic        busy;

  logic [3:0]  req2;
  logic [31:0] wdata2;
  logic [7:0]  latch_d2;
  logic        latch_en2;
  logic [3:0]  ack2;
  logic [1:0]  gnt_id2;
  logic        busy2;

  always #5 clk = ~clk;

  latch_write_sequencer #(
    .NREQ(4), .DW(8), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .latch_d(latch_d),
    .latch_en(latch_en), .ack(ack), .gnt_id(gnt_id), .busy(busy)
  );

  latch_write_sequencer #(
    .NREQ(4), .DW(8), .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)
  ) dut_sw (
    .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata2), .latch_d(latch_d2),
    .latch_en(latch_en2), .ack(ack2), .gnt_id(gnt_id2), .busy(busy2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model: phase = cycles since the grant edge (0 = idle).
  int         m_phase, m_p, m_w;
  logic [7:0] m_d;
  logic       prev_en;
  logic [7:0] prev_d;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    int          exp_gnt;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_p = 0; m_w = 0; m_d = '0; prev_en = 1'b0; prev_d = '0;
  endtask

  task automatic model_edge();
    bit found;
    if (m_phase == 0) begin
      if (req != 4'b0) begin
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req[(m_p + i) % NREQ]) begin
            m_w = (m_p + i) % NREQ;
            found = 1;
          end
        end
        m_d = wdata[m_w*8 +: 8];
        m_p = (m_w + 1) % NREQ;
        m_phase = 1;
      end
    end else if (m_phase == L) m_phase = 0;
    else m_phase++;
  endtask

  task automatic model_check();
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("latch_en", 32'(latch_en), 32'(m_phase > S && m_phase <= S + E));
    chk("ack", 32'(ack), (m_phase == L) ? (32'd1 << m_w) : 32'd0);
    chk("latch_d", 32'(latch_d), 32'(m_d));
    chk("gnt_id", 32'(gnt_id), 32'(m_w));
    if (latch_en && prev_en) chk("latch_d_stable_while_en", 32'(latch_d), 32'(prev_d));
    prev_en = latch_en;
    prev_d  = latch_d;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; wdata = '0; req2 = '0; wdata2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int gcy[5];
    int gid[5];
    int ng, cy;
    logic pb;
    int ack_n, en_n, en_first, busy_n;
    logic [3:0] ack_v;

    tbl[0] = '{4'b0010, 32'h1122A533, 1, 8'hA5};
    tbl[1] = '{4'b0100, 32'h005C0000, 2, 8'h5C};
    tbl[2] = '{4'b1001, 32'hC300007E, 3, 8'hC3};
    tbl[3] = '{4'b1001, 32'h19000042, 0, 8'h42};
    tbl[4] = '{4'b0001, 32'h000000E7, 0, 8'hE7};
    tbl[5] = '{4'b1100, 32'h88990000, 2, 8'h99};

    do_reset();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_latch_en", 32'(latch_en), 32'd0);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_gnt_id", 32'(gnt_id), 32'd0);
    chk("reset_latch_d", 32'(latch_d), 32'd0);
    chk("reset_sw_busy", 32'(busy2), 32'd0);

    // Directed vector table (pointer evolves across entries).
    for (int v = 0; v < 6; v++) begin
      req = tbl[v].req; wdata = tbl[v].wdata;
      cyc();
      req = '0; wdata = $urandom;
      chk("tbl_gnt_id", 32'(gnt_id), 32'(tbl[v].exp_gnt));
      chk("tbl_latch_d", 32'(latch_d), 32'(tbl[v].exp_d));
      for (int k = 2; k <= L; k++) begin
        cyc();
        wdata = $urandom;
        if (k == L) chk("tbl_ack", 32'(ack), 32'd1 << tbl[v].exp_gnt);
      end
      cyc();
    end

    // Asynchronous reset in the middle of ENABLE.
    req = 4'b0010; wdata = $urandom;
    cyc();
    req = '0;
    cyc();
    chk("pre_reset_en", 32'(latch_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_latch_en", 32'(latch_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ack", 32'(ack), 32'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    req = 4'b1111; wdata = $urandom;
    cyc();
    req = '0;
    chk("post_reset_first_gnt", 32'(gnt_id), 32'd0);
    repeat (L) cyc();

    // Fairness with all requests held high.
    do_reset();
    req = 4'b1111;
    ng = 0; cy = 0; pb = 1'b0;
    while (ng < 5 && cy < 60) begin
      wdata = $urandom;
      cyc();
      cy++;
      if (busy && !pb) begin
        gcy[ng] = cy; gid[ng] = int'(gnt_id); ng++;
      end
      pb = busy;
    end
    chk("fair_grant_count", 32'(ng), 32'd5);
    for (int i = 0; i < ng; i++) begin
      chk("fair_order", 32'(gid[i]), 32'(i % NREQ));
      if (i > 0) chk("fair_spacing", 32'(gcy[i] - gcy[i-1]), 32'(L + 1));
    end
    req = '0;
    repeat (L + 1) cyc();

    // Stability: wdata[0] changes every cycle during a requester-0 write.
    req = 4'b0001; wdata = 32'h0000005A;
    cyc();
    req = '0;
    for (int k = 1; k <= L + 1; k++) begin
      chk("stable_latch_d", 32'(latch_d), 32'h5A);
      wdata = $urandom;
      if (k <= L) cyc();
    end

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      wdata = $urandom;
      cyc();
    end
    req = '0;
    repeat (L + 1) cyc();

    // Timing sweep instance: SETUP=3, EN=1, HOLD=2.
    req2 = 4'b0100; wdata2 = 32'h003C0000;
    @(posedge clk);
    #1 req2 = '0; wdata2 = $urandom;
    ack_n = -1; en_n = 0; en_first = -1; busy_n = 0; ack_v = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      wdata2 = $urandom;
      if (ack2 != 4'b0 && ack_n < 0) begin ack_n = n; ack_v = ack2; end
      if (latch_en2) begin
        en_n++;
        if (en_first < 0) en_first = n;
      end
      if (busy2) busy_n++;
      if (n <= 6) chk("sw_latch_d", 32'(latch_d2), 32'h3C);
    end
    chk("sw_ack_latency", 32'(ack_n), 32'd6);
    chk("sw_ack_value", 32'(ack_v), 32'b0100);
    chk("sw_en_cycles", 32'(en_n), 32'd1);
    chk("sw_en_first", 32'(en_first), 32'd4);
    chk("sw_busy_cycles", 32'(busy_n), 32'd6);
    chk("sw_gnt_id", 32'(gnt_id2), 32'd2);
    chk("sw_latch_d_idle", 32'(latch_d2), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
